// File: rtl/aha_clock_select_ctrl.sv
// aha_clock_select_ctrl: request/handshake controller driving SELECT of the glitch-free clock switch.
// Optional source-alive checking is enabled by defining AHA_CLKSEL_SRC_CHECK_EN.
`default_nettype none

module aha_clock_select_ctrl #(
   parameter bit RESET_SEL     = 1'b0,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = 8
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ_VALID,
   input  logic       REQ_SEL,
   output logic       REQ_READY,
   input  logic [1:0] SRC_OK,
   output logic       SELECT,
   output logic       BUSY,
   output logic       DONE,
   output logic       ERR
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      SETTLE = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] counter;
   logic             req_q;
   logic             prev_q;
   logic             target_ok;
   logic             current_ok;

`ifdef AHA_CLKSEL_SRC_CHECK_EN
   assign target_ok  = SRC_OK[req_q];
   assign current_ok = SRC_OK[SELECT];
`else
   // Without source checking every request is assumed to target a live clock.
   logic unused_src_ok;
   assign unused_src_ok = ^SRC_OK;
   assign target_ok     = 1'b1;
   assign current_ok    = 1'b1;
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         counter   <= '0;
         req_q     <= 1'b0;
         prev_q    <= RESET_SEL;
         SELECT    <= RESET_SEL;
         REQ_READY <= 1'b1;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         ERR       <= 1'b0;
      end else begin
         DONE <= 1'b0;
         ERR  <= 1'b0;
         case (state)
            IDLE: begin
               if (REQ_VALID && REQ_READY) begin
                  req_q     <= REQ_SEL;
                  state     <= CHECK;
                  REQ_READY <= 1'b0;
                  BUSY      <= 1'b1;
               end
            end
            CHECK: begin
               if (req_q == SELECT) begin
                  state <= RESP;
                  DONE  <= 1'b1;
               end else if (!target_ok) begin
                  state <= RESP;
                  ERR   <= 1'b1;
               end else begin
                  prev_q  <= SELECT;
                  SELECT  <= req_q;
                  counter <= SETTLE_LOAD;
                  state   <= SETTLE;
               end
            end
            SETTLE: begin
               // A dying target aborts immediately and restores the previous source.
               if (!current_ok) begin
                  SELECT <= prev_q;
                  state  <= RESP;
                  ERR    <= 1'b1;
               end else if (counter == '0) begin
                  state <= RESP;
                  DONE  <= 1'b1;
               end else begin
                  counter <= counter - 1'b1;
               end
            end
            RESP: begin
               state     <= IDLE;
               REQ_READY <= 1'b1;
               BUSY      <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               REQ_READY <= 1'b1;
               BUSY      <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
